// File: rtl/mips_branch_predictor.sv
// ---------------------------------------------------------------------------
// mips_branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters for a word-addressed MIPS fetch stage. Lookup is purely
// combinational from the stored entries; resolved branches from decode
// update (or allocate) one entry per clock.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   asynchronous active-high reset
//   lookup_pc    in   fetch-stage PC (word address)
//   pred_taken   out  predicted taken for lookup_pc
//   pred_target  out  predicted next PC (stored target or lookup_pc+1)
//   pred_hit     out  valid entry with matching tag for lookup_pc
//   upd_valid    in   resolved-branch update strobe
//   upd_pc       in   PC of the resolved branch/jump
//   upd_taken    in   resolved direction
//   upd_target   in   resolved target
//   upd_mispred  in   misprediction flag, qualified by upd_valid
//   flush        in   synchronous invalidate of every entry
//   mispred_cnt  out  saturating misprediction count
// ---------------------------------------------------------------------------
module mips_branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispred,
  input  logic              flush,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(1 << (CNT_W - 1)); // weakly taken
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Flattened view of every entry, gathered from the per-entry registers.
  logic              entry_valid  [ENTRIES];
  logic [TAG_W-1:0]  entry_tag    [ENTRIES];
  logic [ADDR_W-1:0] entry_target [ENTRIES];
  logic [CNT_W-1:0]  entry_cnt    [ENTRIES];

  // -------------------------------------------------------------------------
  // Lookup: zero-latency read of the current (pre-update) contents.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx = lookup_pc[IDX_W-1:0];
  assign lk_tag = lookup_pc[ADDR_W-1:IDX_W];

  always_comb begin
    pred_hit    = entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
    pred_taken  = pred_hit && entry_cnt[lk_idx][CNT_W-1];
    pred_target = pred_taken ? entry_target[lk_idx] : (lookup_pc + ADDR_W'(1));
  end

  // -------------------------------------------------------------------------
  // Update: build the replacement contents for the addressed entry once;
  // each entry then only has to decide whether it is the one being written.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_hit;
  logic              upd_write;
  logic [ADDR_W-1:0] upd_target_new;
  logic [CNT_W-1:0]  upd_cnt_new;

  assign upd_idx = upd_pc[IDX_W-1:0];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W];
  assign upd_hit = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);

  always_comb begin
    upd_write      = 1'b0;
    upd_target_new = entry_target[upd_idx];
    upd_cnt_new    = entry_cnt[upd_idx];
    if (upd_valid) begin
      if (upd_hit) begin
        upd_write = 1'b1;
        if (upd_taken) begin
          upd_target_new = upd_target;
          if (entry_cnt[upd_idx] != CNT_MAX) begin
            upd_cnt_new = entry_cnt[upd_idx] + CNT_W'(1);
          end
        end else if (entry_cnt[upd_idx] != '0) begin
          upd_cnt_new = entry_cnt[upd_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Only taken branches earn a slot; a not-taken miss leaves the
        // entry (and whoever currently owns it) untouched.
        upd_write      = 1'b1;
        upd_target_new = upd_target;
        upd_cnt_new    = CNT_INIT;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Entry storage, one register set per BTB slot.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    logic              valid_q,  valid_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              sel;

    assign sel = upd_write && (upd_idx == IDX_W'(gi));

    always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      if (flush) begin
        // Flush wins over a same-cycle update: only the valid bits drop,
        // counters and targets keep their trained values.
        valid_d = 1'b0;
      end else if (sel) begin
        valid_d  = 1'b1;
        tag_d    = upd_tag;
        target_d = upd_target_new;
        cnt_d    = upd_cnt_new;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q  <= 1'b0;
        tag_q    <= '0;
        target_q <= '0;
        cnt_q    <= '0;
      end else begin
        valid_q  <= valid_d;
        tag_q    <= tag_d;
        target_q <= target_d;
        cnt_q    <= cnt_d;
      end
    end

    assign entry_valid[gi]  = valid_q;
    assign entry_tag[gi]    = tag_q;
    assign entry_target[gi] = target_q;
    assign entry_cnt[gi]    = cnt_q;
  end

  // -------------------------------------------------------------------------
  // Misprediction statistics: independent of flush, saturating.
  // -------------------------------------------------------------------------
  logic [STAT_W-1:0] mispred_q, mispred_d;

  always_comb begin
    mispred_d = mispred_q;
    if (upd_valid && upd_mispred && (mispred_q != STAT_MAX)) begin
      mispred_d = mispred_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispred_q <= '0;
    end else begin
      mispred_q <= mispred_d;
    end
  end

  assign mispred_cnt = mispred_q;

endmodule

// File: doc/mips_branch_predictor.md
MIPS_BRANCH_PREDICTOR -- requirements
Module: mips_branch_predictor

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32: PC/target width in words (the core's PC is word-addressed and increments by 1).
REQ-002 SHALL provide parameter ENTRIES, default 16: number of BTB entries; power of two, minimum 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL provide parameter CNT_W, default 2: saturating-counter width, minimum 1.
REQ-004 SHALL provide parameter STAT_W, default 16: misprediction counter width.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 lookup_pc  in  ADDR_W  fetch-stage PC.
REQ-008 pred_taken  out  1  predicted taken for lookup_pc.
REQ-009 pred_target  out  ADDR_W  predicted next PC.
REQ-010 pred_hit  out  1  BTB hit for lookup_pc.
REQ-011 upd_valid  in  1  resolved-branch update strobe from decode.
REQ-012 upd_pc  in  ADDR_W  PC of the resolved branch or jump.
REQ-013 upd_taken  in  1  resolved direction.
REQ-014 upd_target  in  ADDR_W  resolved target.
REQ-015 upd_mispred  in  1  core detected a misprediction; qualified by upd_valid.
REQ-016 flush  in  1  synchronous invalidate of all entries.
REQ-017 mispred_cnt  out  STAT_W  count of mispredictions.

Function
REQ-018 Entry fields SHALL be: valid, tag = pc[ADDR_W-1:IDX_W], target (ADDR_W), counter (CNT_W).
REQ-019 Index SHALL be pc[IDX_W-1:0] for both lookup and update.
REQ-020 Lookup SHALL be combinational from the stored state with zero-cycle latency.
  - pred_hit = valid && tag match.
  - pred_taken = pred_hit && counter MSB.
  - pred_target = stored target when pred_taken, else lookup_pc+1 (mod 2^ADDR_W).
REQ-021 Update on a hit for upd_pc SHALL behave as follows.
  - Counter: +1 when upd_taken, -1 otherwise; saturate at 2^CNT_W-1 and at 0.
  - Target: overwritten with upd_target only when upd_taken.
REQ-022 Update on a miss (invalid entry or tag mismatch) SHALL behave as follows.
  - upd_taken=1: allocate or replace the entry: valid=1, new tag, target=upd_target, counter = 2^(CNT_W-1) (weakly taken).
  - upd_taken=0: no state change.
REQ-023 State writes SHALL take effect at the edge ending the upd_valid cycle. A same-cycle lookup of the same index SHALL see the pre-update contents.
REQ-024 flush=1 SHALL clear every valid bit at the next edge, leaving counters and targets unchanged. flush SHALL take priority over a simultaneous upd_valid, whose entry write is discarded.
REQ-025 mispred_cnt SHALL increment by 1 on each edge where upd_valid && upd_mispred, and SHALL saturate at 2^STAT_W-1. flush SHALL NOT affect mispred_cnt; a same-cycle mispredict is still counted.
REQ-026 Inputs are assumed to be driven with no X. Any upd_pc value is legal, including 0 and all-ones.

Reset
REQ-027 While rst=1, all valid bits, counters, targets and mispred_cnt SHALL be 0, asynchronously.
  - Outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+1, mispred_cnt=0.
REQ-028 Assertion of rst mid-operation SHALL discard any update in flight. The first edge after deassertion SHALL process inputs normally.

Verification
REQ-029 Post-reset lookup: lookup_pc=0x20 -> pred_hit=0, pred_taken=0, pred_target=0x21, mispred_cnt=0.
REQ-030 Allocation: update (pc=0x23, taken, target=0x10) -> next cycle, lookup 0x23 gives pred_hit=1, pred_taken=1, pred_target=0x10 (counter=2).
REQ-031 Saturation on 0x23 from counter=2:
  - Not-taken updates: 1 NT -> counter=1, pred_taken=0, pred_target=0x24; 2nd NT -> 0; 3rd NT -> stays 0.
  - Taken updates: 2 T -> counter=2, pred_taken=1; 2 more T -> counter=3 (saturated).
REQ-032 Aliasing with ENTRIES=16: with 0x23 allocated, lookup 0x13 -> pred_hit=0.
  - Taken update (0x13, target=0x40) -> 0x13 hits with target 0x40; 0x23 now misses.
  - Not-taken update of 0x33 -> no change.
REQ-033 Flush: flush together with a taken update of 0x05 -> next cycle, lookups of 0x05 and 0x23 both miss, and mispred_cnt is unchanged unless upd_mispred=1.
REQ-034 Counter limits and reset:
  - 2^STAT_W+2 mispredict updates -> mispred_cnt=0xFFFF.
  - Asynchronous rst pulse between edges -> mispred_cnt=0 and pred_hit=0 immediately, without waiting for a clock edge.
